// File: rtl/io_bus_ctrl.sv
// Memory-mapped IO bridge: status/rx/tx UART registers plus a counter window. Loads return on mem_rdata one cycle after mem_re.
// Tx stores that find the FIFO full are dropped and latch tx_overflow. Rx is held off via uart_rx_ready until the byte is read.

// Generic circular FIFO; head visible one cycle after push into empty, pushes while full are ignored.
module io_bus_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module io_bus_ctrl #(
  parameter int TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic        mem_re,
  output logic [31:0] mem_rdata,
  output logic [31:0] cnt_addr,
  output logic        cnt_we,
  output logic [31:0] cnt_din,
  input  logic [31:0] cnt_dout,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);
  localparam logic [31:0] ADDR_STATUS = 32'h8000_0000;
  localparam logic [31:0] ADDR_RX     = 32'h8000_0004;
  localparam logic [31:0] ADDR_TX     = 32'h8000_0008;
  localparam logic [31:0] ADDR_CNT0   = 32'h8000_0010;
  localparam logic [31:0] ADDR_CNT1   = 32'h8000_0014;
  localparam logic [31:0] ADDR_CNT2   = 32'h8000_0018;

  logic        hit_status;
  logic        hit_rx;
  logic        hit_tx;
  logic        hit_cnt;
  logic        tx_push;
  logic        tx_pop;
  logic        tx_full;
  logic        tx_empty;
  logic        tx_overflow;
  logic        ovf_set;
  logic        ovf_clr;
  logic        rx_full;
  logic [7:0]  rx_byte;
  logic        rx_capture;
  logic        rx_read;
  logic [31:0] status_word;
  logic [31:0] rx_word;
  logic [31:0] rdata_q;
  logic        sel_cnt_q;

  assign hit_status = (mem_addr == ADDR_STATUS);
  assign hit_rx     = (mem_addr == ADDR_RX);
  assign hit_tx     = (mem_addr == ADDR_TX);
  assign hit_cnt    = (mem_addr == ADDR_CNT0) || (mem_addr == ADDR_CNT1) ||
                      (mem_addr == ADDR_CNT2);

  assign cnt_addr = mem_addr;
  assign cnt_din  = mem_wdata;
  assign cnt_we   = mem_we & hit_cnt;

  assign tx_push       = mem_we & hit_tx;
  assign tx_pop        = uart_tx_valid & uart_tx_ready;
  assign uart_tx_valid = ~tx_empty;

  io_bus_fifo #(
    .DEPTH (TX_DEPTH),
    .W     (8)
  ) u_tx_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tx_push),
    .push_dat (mem_wdata[7:0]),
    .pop      (tx_pop),
    .head_dat (uart_tx_data),
    .full     (tx_full),
    .empty    (tx_empty)
  );

  // Fullness is judged before this cycle's pop, so a concurrent pop never rescues a push.
  assign ovf_set = tx_push & tx_full;
  assign ovf_clr = mem_we & hit_status & mem_wdata[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_overflow <= 1'b0;
    end else if (ovf_set) begin
      tx_overflow <= 1'b1;
    end else if (ovf_clr) begin
      tx_overflow <= 1'b0;
    end
  end

  assign uart_rx_ready = ~rx_full;
  assign rx_capture    = uart_rx_valid & uart_rx_ready;
  assign rx_read       = mem_re & hit_rx & rx_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_full <= 1'b0;
      rx_byte <= '0;
    end else if (rx_capture) begin
      rx_full <= 1'b1;
      rx_byte <= uart_rx_data;
    end else if (rx_read) begin
      rx_full <= 1'b0;
    end
  end

  assign status_word = {28'b0, tx_empty, tx_overflow, rx_full, ~tx_full};
  assign rx_word     = rx_full ? {24'b0, rx_byte} : 32'b0;

  // Counter reads bypass rdata_q because cnt_dout is already registered upstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q   <= '0;
      sel_cnt_q <= 1'b0;
    end else begin
      sel_cnt_q <= mem_re & hit_cnt;
      if (mem_re && hit_status) begin
        rdata_q <= status_word;
      end else if (mem_re && hit_rx) begin
        rdata_q <= rx_word;
      end else begin
        rdata_q <= '0;
      end
    end
  end

  assign mem_rdata = sel_cnt_q ? cnt_dout : rdata_q;
endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl: register map, tx FIFO ordering/overflow, rx holding and async reset.
module tb_io_bus_ctrl;
  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic [31:0] cnt_addr;
  logic        cnt_we;
  logic [31:0] cnt_din;
  logic [31:0] cnt_dout;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  io_bus_ctrl #(.TX_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_re        (mem_re),
    .mem_rdata     (mem_rdata),
    .cnt_addr      (cnt_addr),
    .cnt_we        (cnt_we),
    .cnt_din       (cnt_din),
    .cnt_dout      (cnt_dout),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    mem_addr  = a;
    mem_wdata = d;
    mem_we    = 1'b1;
    tick();
    mem_we    = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a;
    mem_re   = 1'b1;
    tick();
    mem_re   = 1'b0;
    d        = mem_rdata;
  endtask

  initial begin
    rst_n         = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    cnt_dout      = '0;
    uart_tx_ready = 1'b0;
    uart_rx_data  = '0;
    uart_rx_valid = 1'b0;
    tick();
    tick();
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("rst_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    do_load(32'h8000_0000, rd);
    check("status_after_reset", rd, 32'h9);

    // Fill the FIFO with the transmitter stalled; the fifth byte overflows.
    for (int i = 0; i < 5; i++) begin
      do_store(32'h8000_0008, 32'h41 + i);
    end
    check("tx_valid_full", {31'b0, uart_tx_valid}, 32'h1);
    do_load(32'h8000_0000, rd);
    check("status_full_ovf", rd, 32'h4);

    uart_tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", {31'b0, uart_tx_valid}, 32'h1);
      check("drain_data", {24'b0, uart_tx_data}, 32'h41 + i);
      tick();
    end
    check("drain_empty", {31'b0, uart_tx_valid}, 32'h0);
    uart_tx_ready = 1'b0;
    do_load(32'h8000_0000, rd);
    check("status_empty_ovf", rd, 32'hD);
    do_store(32'h8000_0000, 32'h4);
    do_load(32'h8000_0000, rd);
    check("status_ovf_cleared", rd, 32'h9);

    // Rx holding register; a second byte while full must not overwrite.
    uart_rx_data  = 8'h5A;
    uart_rx_valid = 1'b1;
    tick();
    uart_rx_data  = 8'h77;
    check("rx_ready_low", {31'b0, uart_rx_ready}, 32'h0);
    tick();
    uart_rx_valid = 1'b0;
    do_load(32'h8000_0000, rd);
    check("status_rx_full", rd, 32'hB);
    do_load(32'h8000_0004, rd);
    check("rx_data", rd, 32'h5A);
    check("rx_ready_back", {31'b0, uart_rx_ready}, 32'h1);
    do_load(32'h8000_0004, rd);
    check("rx_empty_read", rd, 32'h0);

    // Counter window.
    mem_addr  = 32'h8000_0018;
    mem_wdata = 32'h1234_5678;
    mem_we    = 1'b1;
    #1;
    check("cnt_we_hit", {31'b0, cnt_we}, 32'h1);
    check("cnt_din", cnt_din, 32'h1234_5678);
    check("cnt_addr", cnt_addr, 32'h8000_0018);
    tick();
    mem_we   = 1'b0;
    mem_addr = 32'h8000_0010;
    mem_re   = 1'b1;
    tick();
    mem_re   = 1'b0;
    cnt_dout = 32'hCAFE_0010;
    #1;
    check("cnt_readback", mem_rdata, 32'hCAFE_0010);
    tick();
    check("no_load_zero", mem_rdata, 32'h0);
    cnt_dout = 32'h0;
    do_load(32'h8000_0020, rd);
    check("unmapped_zero", rd, 32'h0);
    mem_addr  = 32'h8000_0008;
    mem_wdata = 32'h61;
    mem_we    = 1'b1;
    #1;
    check("cnt_we_miss", {31'b0, cnt_we}, 32'h0);
    tick();
    mem_we = 1'b0;

    // Three entries queued, then push and pop together.
    do_store(32'h8000_0008, 32'h62);
    do_store(32'h8000_0008, 32'h63);
    uart_tx_ready = 1'b1;
    check("pp_head", {24'b0, uart_tx_data}, 32'h61);
    do_store(32'h8000_0008, 32'h64);
    uart_tx_ready = 1'b0;
    do_load(32'h8000_0000, rd);
    check("status_count3", rd, 32'h1);
    uart_tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("pp_order", {24'b0, uart_tx_data}, 32'h62 + i);
      tick();
    end
    check("pp_empty", {31'b0, uart_tx_valid}, 32'h0);
    uart_tx_ready = 1'b0;

    // Full FIFO: a push coinciding with a pop is still dropped.
    for (int i = 0; i < 4; i++) begin
      do_store(32'h8000_0008, 32'h50 + i);
    end
    uart_tx_ready = 1'b1;
    do_store(32'h8000_0008, 32'h5F);
    uart_tx_ready = 1'b0;
    do_load(32'h8000_0000, rd);
    check("status_pop_no_rescue", rd, 32'h5);
    uart_tx_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      check("norescue_order", {24'b0, uart_tx_data}, 32'h50 + i);
      tick();
    end
    check("norescue_empty", {31'b0, uart_tx_valid}, 32'h0);
    uart_tx_ready = 1'b0;
    do_store(32'h8000_0000, 32'h4);

    // Reset mid-transfer clears the queue asynchronously.
    do_store(32'h8000_0008, 32'h71);
    do_store(32'h8000_0008, 32'h72);
    check("pre_reset_valid", {31'b0, uart_tx_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", {31'b0, uart_tx_valid}, 32'h0);
    check("async_reset_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_valid", {31'b0, uart_tx_valid}, 32'h0);
    do_load(32'h8000_0000, rd);
    check("status_post_reset", rd, 32'h9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_bus_ctrl.md
IO_BUS_CTRL -- requirements
Module: io_bus_ctrl

Interface
REQ-001 Parameter: TX_DEPTH, 4, UART transmit FIFO depth in entries; SHALL be a power of two and at least 2.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 mem_addr  in  32  byte address of the CPU memory-stage access.
REQ-005 mem_wdata  in  32  CPU store data.
REQ-006 mem_we  in  1  store strobe, valid for one cycle per store.
REQ-007 mem_re  in  1  load strobe, valid for one cycle per load.
REQ-008 mem_rdata  out  32  registered load data, valid the cycle after mem_re.
REQ-009 cnt_addr  out  32  counter address, driven equal to mem_addr.
REQ-010 cnt_we  out  1  counter write strobe.
REQ-011 cnt_din  out  32  counter write data, driven equal to mem_wdata.
REQ-012 cnt_dout  in  32  registered counter read data, one-cycle latency.
REQ-013 uart_tx_data  out  8  transmit byte, taken from the FIFO head.
REQ-014 uart_tx_valid  out  1  FIFO non-empty.
REQ-015 uart_tx_ready  in  1  transmitter accepts the byte when valid and ready are both high.
REQ-016 uart_rx_data  in  8  received byte.
REQ-017 uart_rx_valid  in  1  received byte is present.
REQ-018 uart_rx_ready  out  1  equal to NOT rx_full.

Function
REQ-019 The address map SHALL be:
- 0x80000000: status (R) / clear (W).
- 0x80000004: rx data (R).
- 0x80000008: tx data (W).
- 0x80000010, 0x80000014, 0x80000018: counter window.
- All other addresses: not mapped by this block.
REQ-020 cnt_we SHALL equal mem_we AND (mem_addr is 0x80000010, 0x80000014 or 0x80000018); the path is combinational.
REQ-021 A store to 0x80000008 SHALL push mem_wdata[7:0] into the tx FIFO only when the FIFO is not full at the start of that cycle.
REQ-022 A push while full SHALL be dropped and SHALL set the sticky tx_overflow flag; a same-cycle pop SHALL NOT rescue the push.
REQ-023 The FIFO SHALL pop on uart_tx_valid AND uart_tx_ready; pop and push in the same cycle SHALL leave the count unchanged.
REQ-024 Pointers SHALL wrap modulo TX_DEPTH; the count SHALL range 0..TX_DEPTH.
REQ-025 A byte pushed into an empty FIFO SHALL appear on uart_tx_valid/uart_tx_data the next cycle; there is no bypass.
REQ-026 The rx holding register SHALL capture uart_rx_data when uart_rx_valid AND uart_rx_ready, and SHALL set rx_full.
REQ-027 A load from 0x80000004 SHALL return {24'b0, rx_byte} and clear rx_full.
REQ-028 A load from 0x80000004 with rx_full=0 SHALL return 0 and change no state.
REQ-029 Status word: bit0 = tx not full; bit1 = rx_full; bit2 = tx_overflow; bit3 = tx empty; bits[31:4] = 0.
REQ-030 A store to 0x80000000 with wdata[2]=1 SHALL clear tx_overflow.
REQ-031 If a clear and a new overflow occur in the same cycle, the flag SHALL remain set.
REQ-032 Read latency SHALL be exactly 1 cycle for every address.
REQ-033 The block SHALL register a read-select on mem_re; the following cycle mem_rdata SHALL be:
- the registered status or rx word, or
- cnt_dout passed through for counter-window addresses, or
- 0 for unmapped addresses or when no load was issued.
REQ-034 Simultaneous mem_re and mem_we SHALL be treated as both occurring; each SHALL be decoded independently.

Reset
REQ-035 While rst_n=0 the block SHALL hold the following:
- FIFO empty, pointers 0;
- rx_full=0, tx_overflow=0;
- read-select cleared;
- mem_rdata=0;
- uart_tx_valid=0, uart_rx_ready=1.
REQ-036 Reset assertion mid-transfer SHALL discard FIFO contents immediately and asynchronously; release SHALL be sampled synchronously with no glitch on uart_tx_valid.

Verification
REQ-037 Reset, then load 0x80000000 -> mem_rdata=0x00000009 one cycle later.
REQ-038 With uart_tx_ready=0, store 0x41,0x42,0x43,0x44,0x45 to 0x80000008 -> status=0x00000004; raising ready emits 0x41..0x44 in order; then status=0x0000000D; write 0x4 to 0x80000000 -> status=0x00000009.
REQ-039 Drive rx byte 0x5A -> uart_rx_ready falls, status bit1=1; load 0x80000004 -> 0x0000005A; next load -> 0.
REQ-040 Store to 0x80000018 -> cnt_we=1 that cycle; load 0x80000010 -> mem_rdata equals cnt_dout one cycle later; store to 0x80000008 -> cnt_we=0.
REQ-041 FIFO at 3 entries, push and pop in the same cycle -> count stays 3, order preserved.
REQ-042 Assert rst_n=0 with 2 bytes queued -> uart_tx_valid=0 before the next clock edge; after release, status=0x00000009.
